// File: rtl/jtframe_joyser_if.sv
// Bus between jtframe_joyser and its users: shift-register chain pins plus the
// published joystick word with its frame/change strobes and an FSM debug view.
interface jtframe_joyser_if #(
  parameter int W = 24
);
  logic         joy_clk;
  logic         joy_load;
  logic         joy_data;
  logic [W-1:0] joystick;
  logic         frame_done;
  logic         changed;
  logic [1:0]   dbg_state;

  modport master (
    output joy_clk, joy_load, joystick, frame_done, changed, dbg_state,
    input  joy_data
  );

  modport slave (
    input  joy_clk, joy_load, joystick, frame_done, changed, dbg_state,
    output joy_data
  );
endinterface

// File: rtl/jtframe_joyser.sv
// Serial joystick reader for a parallel-in/serial-out chain, player-packed output.
// Optional macro JOYSER_DEBOUNCE_EN: publish only when two consecutive frames agree.
module jtframe_joyser #(
  parameter int PLAYERS = 2,
  parameter int BUTTONS = 12,
  parameter int DIV     = 8,
  parameter int GAP     = 1
) (
  input  logic             clk_sys,
  input  logic             rst,
  jtframe_joyser_if.master bus
);
  localparam int N  = PLAYERS * BUTTONS;
  localparam int CW = $clog2(N + GAP + 1);
  localparam logic [DIV-1:0] RISE_AT  = {1'b0, {(DIV-1){1'b1}}};
  localparam logic [CW-1:0]  LAST_BIT = CW'(N - 1);
  localparam logic [CW-1:0]  LAST_GAP = CW'(N + GAP - 1);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_LEAD,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t         state, state_next;
  logic [DIV-1:0] cnt;
  logic           rise;
  logic [1:0]     sync;
  logic           load_r, load_next;
  logic [CW-1:0]  bitcnt, bitcnt_next;
  logic           shift_en;
  logic           last_bit;
  logic [N-1:0]   sr, sr_next;
  logic           publish;
  logic [N-1:0]   joy_r, joy_new;
  logic           frame_done_r, changed_r;

  assign rise = (cnt == RISE_AT);

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      cnt    <= '0;
      sync   <= 2'b11;
      state  <= ST_LOAD;
      load_r <= 1'b1;
      bitcnt <= '0;
      sr     <= '1;
    end else begin
      cnt    <= cnt + 1'b1;
      sync   <= {sync[0], bus.joy_data};
      state  <= state_next;
      load_r <= load_next;
      bitcnt <= bitcnt_next;
      sr     <= sr_next;
    end
  end

  // Out of reset LOAD is entered with joy_load still high, so its first rise only
  // drops joy_load; later frames enter LOAD with joy_load already low.
  always_comb begin
    state_next  = state;
    load_next   = load_r;
    bitcnt_next = bitcnt;
    shift_en    = 1'b0;
    last_bit    = 1'b0;
    if (rise) begin
      case (state)
        ST_LOAD: begin
          if (load_r) begin
            load_next = 1'b0;
          end else begin
            state_next = ST_LEAD;
            load_next  = 1'b1;
          end
        end
        ST_LEAD: begin
          state_next  = ST_SHIFT;
          bitcnt_next = '0;
        end
        ST_SHIFT: begin
          shift_en    = 1'b1;
          bitcnt_next = bitcnt + 1'b1;
          if (bitcnt == LAST_BIT) begin
            last_bit = 1'b1;
            if (GAP == 0) begin
              state_next = ST_LOAD;
              load_next  = 1'b0;
            end else begin
              state_next = ST_GAP;
            end
          end
        end
        ST_GAP: begin
          bitcnt_next = bitcnt + 1'b1;
          if (bitcnt == LAST_GAP) begin
            state_next = ST_LOAD;
            load_next  = 1'b0;
          end
        end
        default: begin
          state_next = ST_LOAD;
          load_next  = 1'b0;
        end
      endcase
    end
  end

  // MSB-first: the first bit off the chain ends up in sr[N-1].
  always_comb begin
    sr_next = sr;
    if (shift_en) begin
      sr_next    = sr << 1;
      sr_next[0] = sync[1];
    end
  end

`ifdef JOYSER_DEBOUNCE_EN
  logic [N-1:0] prev;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      prev <= '1;
    end else if (publish) begin
      prev <= sr;
    end
  end

  always_comb begin
    joy_new = joy_r;
    if (sr == prev) begin
      joy_new = ~sr;
    end
  end
`else
  always_comb begin
    joy_new = ~sr;
  end
`endif

  // Strobes: frame_done is a one-cycle pulse per completed frame; changed is a
  // one-cycle pulse, only ever together with frame_done, when joystick moves.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      publish      <= 1'b0;
      joy_r        <= '0;
      frame_done_r <= 1'b0;
      changed_r    <= 1'b0;
    end else begin
      publish      <= last_bit;
      frame_done_r <= publish;
      changed_r    <= publish && (joy_new != joy_r);
      if (publish) begin
        joy_r <= joy_new;
      end
    end
  end

  assign bus.joy_clk    = cnt[DIV-1];
  assign bus.joy_load   = load_r;
  assign bus.joystick   = joy_r;
  assign bus.frame_done = frame_done_r;
  assign bus.changed    = changed_r;
  assign bus.dbg_state  = state;
endmodule
